// File: rtl/reg_file_mp.sv
// Two-read/one-write register file with registered reads, optional zero register and a bulk-clear sweep.
// Optional macro RF_BYPASS_EN selects write-first same-address reads; default is read-before-write.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] reg1,
    input  logic [ADDR_W-1:0] reg2,
    input  logic [ADDR_W-1:0] writereg,
    input  logic              write,
    input  logic [DATA_W-1:0] data,
    input  logic              clr,
    output logic [DATA_W-1:0] read1,
    output logic [DATA_W-1:0] read2,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] ptr, next_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd1_next, rd2_next;
    logic              wr_en;
    logic              zero1, zero2, zero_w;

    assign zero1  = (ZERO_REG != 0) && (reg1 == '0);
    assign zero2  = (ZERO_REG != 0) && (reg2 == '0);
    assign zero_w = (ZERO_REG != 0) && (writereg == '0);

    // A clear request in IDLE takes priority over a same-edge write.
    assign wr_en = (state == IDLE) && !clr && write && !zero_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            ptr   <= next_ptr;
            busy  <= (next_state == CLEAR);
        end
    end

    always_comb begin
        next_state = state;
        next_ptr   = ptr;
        case (state)
            IDLE: begin
                if (clr) begin
                    next_state = CLEAR;
                    next_ptr   = '0;
                end
            end
            CLEAR: begin
                if (ptr == LAST) begin
                    next_state = IDLE;
                    next_ptr   = '0;
                end else begin
                    next_ptr = ptr + ADDR_W'(1);
                end
            end
            default: begin
                next_state = IDLE;
                next_ptr   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[ptr] <= '0;
        end else if (wr_en) begin
            mem[writereg] <= data;
        end
    end

    // Zero-register and in-sweep reads override any bypassed write data.
    always_comb begin
        rd1_next = mem[reg1];
        rd2_next = mem[reg2];
`ifdef RF_BYPASS_EN
        if (wr_en && (writereg == reg1)) rd1_next = data;
        if (wr_en && (writereg == reg2)) rd2_next = data;
`endif
        if ((state == CLEAR) || zero1) rd1_next = '0;
        if ((state == CLEAR) || zero2) rd2_next = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read1 <= '0;
            read2 <= '0;
        end else begin
            read1 <= rd1_next;
            read2 <= rd2_next;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp: default instance plus a small ZERO_REG=0 instance.
// Same-edge read/write expectations follow RF_BYPASS_EN.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  reg1, reg2, writereg;
    logic        write, clr;
    logic [31:0] data;
    logic [31:0] read1, read2;
    logic        busy;

    logic [2:0]  s_reg1, s_reg2, s_writereg;
    logic        s_write, s_clr;
    logic [7:0]  s_data;
    logic [7:0]  s_read1, s_read2;
    logic        s_busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file_mp dut (
        .clk(clk), .rst(rst), .reg1(reg1), .reg2(reg2), .writereg(writereg),
        .write(write), .data(data), .clr(clr),
        .read1(read1), .read2(read2), .busy(busy)
    );

    reg_file_mp #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) dut_small (
        .clk(clk), .rst(rst), .reg1(s_reg1), .reg2(s_reg2), .writereg(s_writereg),
        .write(s_write), .data(s_data), .clr(s_clr),
        .read1(s_read1), .read2(s_read2), .busy(s_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        write = 1'b1; writereg = a; data = d;
        step();
        write = 1'b0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        checks++; if (read1 !== 32'h0) begin failures++; $display("[TB] FAIL reset_read1 got=%h exp=0", read1); end
        checks++; if (read2 !== 32'h0) begin failures++; $display("[TB] FAIL reset_read2 got=%h exp=0", read2); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        do_write(5'd9, 32'h0000_0055);
        reg1 = 5'd9;
        step();
        checks++; if (read1 !== 32'h55) begin failures++; $display("[TB] FAIL pre_reset_read1 got=%h exp=00000055", read1); end
        // Asynchronous reset mid-cycle: outputs must clear without a clock edge.
        @(posedge clk); #2 rst = 1'b1; #1;
        checks++; if (read1 !== 32'h0) begin failures++; $display("[TB] FAIL async_reset_read1 got=%h exp=0", read1); end
        @(posedge clk); #2 rst = 1'b0;
        do_write(5'd20, 32'hCAFE_0001);
        clr = 1'b1; step(); clr = 1'b0;
        step(); step(); step();
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL sweep_started busy got=%b exp=1", busy); end
        #2 rst = 1'b1; #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midsweep_reset_busy got=%b exp=0", busy); end
        checks++; if (read1 !== 32'h0 || read2 !== 32'h0) begin failures++; $display("[TB] FAIL midsweep_reset_reads got=%h/%h exp=0/0", read1, read2); end
        @(posedge clk); #2 rst = 1'b0;
        step();
        for (int i = 0; i < 32; i++) begin
            reg1 = 5'(i); reg2 = 5'(31 - i);
            step();
            checks++;
            if (read1 !== 32'h0 || read2 !== 32'h0) begin
                failures++; $display("[TB] FAIL post_reset_zero addr=%0d got=%h/%h exp=0/0", i, read1, read2);
            end
        end
    endtask

    task automatic test_basic();
        $display("[TB] test_basic");
        do_write(5'd7, 32'hDEAD_BEEF);
        reg1 = 5'd7;
        step();
        checks++; if (read1 !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL basic_read1 got=%h exp=deadbeef", read1); end
        do_write(5'd0, 32'h1234_5678);
        reg2 = 5'd0;
        step();
        checks++; if (read2 !== 32'h0) begin failures++; $display("[TB] FAIL zero_reg_read2 got=%h exp=0", read2); end
        reg1 = 5'd7; reg2 = 5'd7;
        step();
        checks++; if (read1 !== 32'hDEAD_BEEF || read2 !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL same_addr_both got=%h/%h exp=deadbeef", read1, read2); end
    endtask

    task automatic test_same_edge();
        logic [31:0] exp_first;
`ifdef RF_BYPASS_EN
        exp_first = 32'h22;
`else
        exp_first = 32'h11;
`endif
        $display("[TB] test_same_edge");
        do_write(5'd3, 32'h11);
        reg1 = 5'd3;
        write = 1'b1; writereg = 5'd3; data = 32'h22;
        step();
        write = 1'b0;
        checks++; if (read1 !== exp_first) begin failures++; $display("[TB] FAIL same_edge_read1 got=%h exp=%h", read1, exp_first); end
        step();
        checks++; if (read1 !== 32'h22) begin failures++; $display("[TB] FAIL same_edge_next got=%h exp=00000022", read1); end
    endtask

    task automatic test_bulk_clear();
        int cnt;
        logic rd_bad;
        $display("[TB] test_bulk_clear");
        for (int i = 1; i < 32; i++) do_write(5'(i), 32'h1000_0000 | i);
        reg1 = 5'd5; reg2 = 5'd31;
        step();
        checks++; if (read2 !== 32'h1000_001F) begin failures++; $display("[TB] FAIL fill_read2 got=%h exp=1000001f", read2); end
        clr = 1'b1; step(); clr = 1'b0;
        cnt = 0; rd_bad = 1'b0;
        // The first busy sample still shows the pre-clear read; zero reads start one edge later.
        while (busy === 1'b1 && cnt < 100) begin
            if (cnt > 0 && (read1 !== 32'h0 || read2 !== 32'h0)) rd_bad = 1'b1;
            cnt++;
            step();
        end
        if (read1 !== 32'h0 || read2 !== 32'h0) rd_bad = 1'b1;
        checks++; if (cnt != 32) begin failures++; $display("[TB] FAIL clear_busy_cycles got=%0d exp=32", cnt); end
        checks++; if (rd_bad) begin failures++; $display("[TB] FAIL clear_reads_zero got=nonzero exp=0"); end
        for (int i = 0; i < 32; i++) begin
            reg1 = 5'(i); reg2 = 5'(i);
            step();
            checks++;
            if (read1 !== 32'h0 || read2 !== 32'h0) begin
                failures++; $display("[TB] FAIL after_clear addr=%0d got=%h/%h exp=0/0", i, read1, read2);
            end
        end
    endtask

    task automatic test_clear_arbitration();
        int cnt;
        $display("[TB] test_clear_arbitration");
        do_write(5'd5, 32'h77);
        clr = 1'b1; write = 1'b1; writereg = 5'd5; data = 32'hAA;
        step();
        clr = 1'b0; write = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            write = (cnt == 10); writereg = 5'd2; data = 32'hBB;
            clr = (cnt == 15);
            step();
        end
        write = 1'b0; clr = 1'b0;
        checks++; if (cnt != 32) begin failures++; $display("[TB] FAIL arb_busy_cycles got=%0d exp=32", cnt); end
        // First idle edge after the sweep must accept a write.
        do_write(5'd4, 32'hCC);
        reg1 = 5'd5; reg2 = 5'd2;
        step();
        checks++; if (read1 !== 32'h0) begin failures++; $display("[TB] FAIL clr_write_dropped got=%h exp=0", read1); end
        checks++; if (read2 !== 32'h0) begin failures++; $display("[TB] FAIL busy_write_dropped got=%h exp=0", read2); end
        reg1 = 5'd4;
        step();
        checks++; if (read1 !== 32'hCC) begin failures++; $display("[TB] FAIL first_write_after_clear got=%h exp=000000cc", read1); end
    endtask

    task automatic test_param();
        int cnt;
        $display("[TB] test_param");
        s_write = 1'b1; s_writereg = 3'd0; s_data = 8'hFF;
        step();
        s_write = 1'b0; s_reg1 = 3'd0;
        step();
        checks++; if (s_read1 !== 8'hFF) begin failures++; $display("[TB] FAIL small_reg0 got=%h exp=ff", s_read1); end
        s_clr = 1'b1; step(); s_clr = 1'b0;
        cnt = 0;
        while (s_busy === 1'b1 && cnt < 100) begin
            cnt++;
            step();
        end
        checks++; if (cnt != 8) begin failures++; $display("[TB] FAIL small_busy_cycles got=%0d exp=8", cnt); end
        step();
        checks++; if (s_read1 !== 8'h00) begin failures++; $display("[TB] FAIL small_reg0_cleared got=%h exp=00", s_read1); end
    endtask

    initial begin
        rst = 1'b1;
        reg1 = '0; reg2 = '0; writereg = '0; write = 1'b0; data = '0; clr = 1'b0;
        s_reg1 = '0; s_reg2 = '0; s_writereg = '0; s_write = 1'b0; s_data = '0; s_clr = 1'b0;
        #22 rst = 1'b0;
        step();
        test_reset();
        test_basic();
        test_same_edge();
        test_bulk_clear();
        test_clear_arbitration();
        test_param();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
